// File: rtl/alsu_pipe.sv
// alsu_pipe: two-stage pipelined arithmetic/logic/shift unit.
// Stage 1 registers operands, opcode and control flags. Stage 2 computes
// and registers the result, the error flag and the LED blink bank. A valid
// qualifier travels alongside the data.
module alsu_pipe #(
  parameter int    WIDTH          = 3,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON",
  parameter int    LED_WIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B,
  input  logic [2:0]             opcode,
  input  logic                   cin,
  input  logic                   serial_in,
  input  logic                   direction,
  input  logic                   red_op_A,
  input  logic                   red_op_B,
  input  logic                   bypass_A,
  input  logic                   bypass_B,
  output logic [2*WIDTH-1:0]     out,
  output logic                   valid_out,
  output logic                   err,
  output logic [LED_WIDTH-1:0]   leds
);

  localparam int OUT_W  = 2 * WIDTH;
  localparam bit PRIO_B = (INPUT_PRIORITY == "B");
  localparam bit FA_ON  = (FULL_ADDER == "ON");

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_XOR   = 3'd1,
    OP_ADD   = 3'd2,
    OP_MUL   = 3'd3,
    OP_SHIFT = 3'd4,
    OP_ROT   = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_e;

  // Stage-1 registers
  logic [WIDTH-1:0] a_q, b_q;
  op_e              op_q;
  logic             cin_q, sin_q, dir_q;
  logic             red_a_q, red_b_q, byp_a_q, byp_b_q;
  logic             s1_valid_q;

  // Stage-2 registers and their next-state values
  logic [OUT_W-1:0]     out_q, out_d;
  logic                 valid_q;
  logic                 err_q, err_d;
  logic [LED_WIDTH-1:0] leds_q, leds_d;

  // Operand selections derived from the registered flags
  logic [WIDTH-1:0] byp_val, red_src;
  logic             bypass, red_any, invalid;

  // Capture all inputs when qualified; contents hold otherwise.
  // NOTE: clocked state is written with <= so every register samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_AND;
      cin_q      <= 1'b0;
      sin_q      <= 1'b0;
      dir_q      <= 1'b0;
      red_a_q    <= 1'b0;
      red_b_q    <= 1'b0;
      byp_a_q    <= 1'b0;
      byp_b_q    <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= valid_in;
      if (valid_in) begin
        a_q     <= A;
        b_q     <= B;
        op_q    <= op_e'(opcode);
        cin_q   <= cin;
        sin_q   <= serial_in;
        dir_q   <= direction;
        red_a_q <= red_op_A;
        red_b_q <= red_op_B;
        byp_a_q <= bypass_A;
        byp_b_q <= bypass_B;
      end
    end
  end

  assign bypass  = byp_a_q | byp_b_q;
  assign red_any = red_a_q | red_b_q;
  assign invalid = (op_q == OP_RSV6) || (op_q == OP_RSV7) ||
                   (red_any && (op_q != OP_AND) && (op_q != OP_XOR));

  // When both flags of a pair are set, the priority operand wins.
  assign byp_val = (byp_a_q && byp_b_q) ? (PRIO_B ? b_q : a_q) :
                   (byp_a_q ? a_q : b_q);
  assign red_src = (red_a_q && red_b_q) ? (PRIO_B ? b_q : a_q) :
                   (red_a_q ? a_q : b_q);

  // Result, error and LED next-state: bypass, then invalid, then opcode.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    out_d  = '0;
    err_d  = 1'b0;
    leds_d = '0;
    if (bypass) begin
      out_d = OUT_W'(byp_val);
    end else if (invalid) begin
      err_d  = 1'b1;
      leds_d = ~leds_q;
    end else begin
      case (op_q)
        OP_AND:   out_d = red_any ? OUT_W'(&red_src) : OUT_W'(a_q & b_q);
        OP_XOR:   out_d = red_any ? OUT_W'(^red_src) : OUT_W'(a_q ^ b_q);
        OP_ADD:   out_d = OUT_W'(a_q) + OUT_W'(b_q) + OUT_W'(cin_q & FA_ON);
        OP_MUL:   out_d = OUT_W'(a_q) * OUT_W'(b_q);
        OP_SHIFT: out_d = dir_q ? {out_q[OUT_W-2:0], sin_q}
                                : {sin_q, out_q[OUT_W-1:1]};
        OP_ROT:   out_d = dir_q ? {out_q[OUT_W-2:0], out_q[OUT_W-1]}
                                : {out_q[0], out_q[OUT_W-1:1]};
        default:  out_d = '0;
      endcase
    end
  end

  // Register the result when stage 1 holds a valid operation; pulse flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      leds_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (s1_valid_q) begin
      out_q   <= out_d;
      leds_q  <= leds_d;
      valid_q <= 1'b1;
      err_q   <= err_d;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end
  end

  assign out       = out_q;
  assign valid_out = valid_q;
  assign err       = err_q;
  assign leds      = leds_q;

endmodule
